// File: rtl/minimig_autoconfig_pkg.sv
// ---------------------------------------------------------------------------
// minimig_autoconfig_pkg
// Shared definitions for the Zorro AutoConfig chain controller: sequencer
// state encoding, config-space register word offsets, board type codes and
// default chain geometry.
// ---------------------------------------------------------------------------
package minimig_autoconfig_pkg;

  // Default chain geometry: six slots, three-bit slot index.
  localparam int NBOARDS_DEF = 6;
  localparam int IDXW_DEF    = 3;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_SCAN,
    ST_PROBE,
    ST_TYPE,
    ST_SERVE,
    ST_DONE
  } ac_state_t;

  // Word offsets inside the $E8xxxx window (byte address bits 6:1).
  localparam logic [5:0] REG_TYPE   = 6'h00;
  localparam logic [5:0] REG_Z3BASE = 6'h22;
  localparam logic [5:0] REG_BASE   = 6'h24;
  localparam logic [5:0] REG_BASELO = 6'h25;
  localparam logic [5:0] REG_SHUTUP = 6'h26;

  // Board type codes found in bits 3:2 of the first ROM nybble.
  localparam logic [1:0] CARD_Z2 = 2'b11;
  localparam logic [1:0] CARD_Z3 = 2'b10;

  // Returns 1 for a Zorro III board. Unknown codes fall back to Zorro II.
  function automatic logic card_is_z3(input logic [1:0] code);
    case (code)
      CARD_Z3: card_is_z3 = 1'b1;
      CARD_Z2: card_is_z3 = 1'b0;
      default: card_is_z3 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/minimig_autoconfig_ctrl.sv
// ---------------------------------------------------------------------------
// minimig_autoconfig_ctrl
// Walks the Zorro AutoConfig chain in slot order, presents the current
// board's AutoConfig ROM nybbles to CPU reads, decodes base-address and
// shut-up writes and reports each assigned base to the address decoders.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   board_en            per-slot enable, sampled while searching for a slot
//   cpu_req/cpu_we      access request (held until cpu_ack) and direction
//   cpu_addr/cpu_din    config-space word offset and write data
//   cpu_dout/cpu_ack    read data {nybble, 12'hfff} and one-cycle ack
//   rom_a/rom_q         external nybble ROM port (2-cycle read latency)
//   base_we/idx/val     one-cycle base assignment report
//   cfg_done/shutup     sticky per-slot configured / shut-up flags
//   chain_done          no further boards remain in config space
// ---------------------------------------------------------------------------
module minimig_autoconfig_ctrl
  import minimig_autoconfig_pkg::*;
#(
  parameter int NBOARDS = NBOARDS_DEF,
  parameter int IDXW    = IDXW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NBOARDS-1:0] board_en,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [5:0]         cpu_addr,
  input  logic [15:0]        cpu_din,
  output logic [15:0]        cpu_dout,
  output logic               cpu_ack,
  output logic [IDXW+5:0]    rom_a,
  input  logic [3:0]         rom_q,
  output logic               base_we,
  output logic [IDXW-1:0]    base_idx,
  output logic [15:0]        base_val,
  output logic [NBOARDS-1:0] cfg_done,
  output logic [NBOARDS-1:0] shutup,
  output logic               chain_done
);

  // The slot counter is one bit wider than the index so that stepping past
  // the last slot is visible even when NBOARDS == 2**IDXW.
  localparam logic [IDXW:0] SLOT_END = (IDXW+1)'(NBOARDS);

  ac_state_t          state, state_d;
  logic [IDXW:0]      slot, slot_d;
  logic [1:0]         wait_cnt;
  logic               busy;
  logic               is_z3;
  logic [3:0]         lo_nyb;

  logic               accept;
  logic               rd_start;
  logic               rd_finish;
  logic               wr_accept;
  logic               done_accept;
  logic               commit_z2;
  logic               commit_z3;
  logic               commit_su;
  logic               commit;
  logic [15:0]        commit_val;
  logic [NBOARDS-1:0] slot_mask;
  logic               slot_en;

  // Request decode. A request is only taken when no read is in flight and
  // the previous ack has dropped, so a held cpu_req is never served twice.
  always_comb begin
    accept      = cpu_req && !busy && !cpu_ack &&
                  (state == ST_SERVE || state == ST_DONE);
    rd_start    = accept && (state == ST_SERVE) && !cpu_we;
    wr_accept   = accept && (state == ST_SERVE) && cpu_we;
    done_accept = accept && (state == ST_DONE);
    rd_finish   = busy && (wait_cnt == 2'd2);

    commit_z2 = wr_accept && (cpu_addr == REG_BASE)   && !is_z3;
    commit_z3 = wr_accept && (cpu_addr == REG_Z3BASE) && is_z3;
    commit_su = wr_accept && (cpu_addr == REG_SHUTUP);
    commit    = commit_z2 || commit_z3 || commit_su;

    commit_val = 16'h0000;
    if (commit_z3) begin
      commit_val = cpu_din;
    end else if (commit_z2) begin
      commit_val = {8'h00, cpu_din[15:12], lo_nyb};
    end

    slot_mask = NBOARDS'(1) << slot;
    slot_en   = (slot < SLOT_END) && board_en[slot[IDXW-1:0]];
  end

  // Next-state logic for the chain sequencer.
  always_comb begin
    state_d = state;
    slot_d  = slot;
    case (state)
      ST_SCAN: begin
        if (slot >= SLOT_END) begin
          state_d = ST_DONE;
        end else if (slot_en) begin
          state_d = ST_PROBE;
        end else begin
          slot_d = slot + 1'b1;
        end
      end
      ST_PROBE: begin
        if (wait_cnt == 2'd1) begin
          state_d = ST_TYPE;
        end
      end
      ST_TYPE: begin
        state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (commit) begin
          state_d = ST_SCAN;
          slot_d  = slot + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // Sequencer state and slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_SCAN;
      slot  <= '0;
    end else begin
      state <= state_d;
      slot  <= slot_d;
    end
  end

  // ROM latency counter and read-in-flight flag. The counter doubles as the
  // two-cycle PROBE wait and the read pipeline tracker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 2'd0;
      busy     <= 1'b0;
    end else begin
      if (state == ST_PROBE) begin
        wait_cnt <= wait_cnt + 2'd1;
      end else if (rd_start) begin
        wait_cnt <= 2'd0;
      end else if (busy) begin
        wait_cnt <= wait_cnt + 2'd1;
      end else begin
        wait_cnt <= 2'd0;
      end

      if (rd_start) begin
        busy <= 1'b1;
      end else if (rd_finish) begin
        busy <= 1'b0;
      end
    end
  end

  // ROM address, board type, low base nybble and CPU read/ack path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_a    <= '0;
      is_z3    <= 1'b0;
      lo_nyb   <= 4'h0;
      cpu_dout <= 16'hffff;
      cpu_ack  <= 1'b0;
    end else begin
      if (state == ST_SCAN && state_d == ST_PROBE) begin
        rom_a <= {slot[IDXW-1:0], REG_TYPE};
      end else if (rd_start) begin
        rom_a <= {slot[IDXW-1:0], cpu_addr};
      end

      if (state == ST_TYPE) begin
        is_z3 <= card_is_z3(rom_q[3:2]);
      end

      // The low nybble belongs to the slot being configured only.
      if (commit) begin
        lo_nyb <= 4'h0;
      end else if (wr_accept && cpu_addr == REG_BASELO) begin
        lo_nyb <= cpu_din[15:12];
      end

      if (rd_finish) begin
        cpu_dout <= {rom_q, 12'hfff};
      end else if (done_accept && !cpu_we) begin
        cpu_dout <= 16'hffff;
      end

      cpu_ack <= rd_finish || wr_accept || done_accept;
    end
  end

  // Base assignment report and sticky per-slot flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_we    <= 1'b0;
      base_idx   <= '0;
      base_val   <= 16'h0000;
      cfg_done   <= '0;
      shutup     <= '0;
      chain_done <= 1'b0;
    end else begin
      base_we    <= commit;
      chain_done <= chain_done || (state_d == ST_DONE);
      if (commit) begin
        base_idx <= slot[IDXW-1:0];
        base_val <= commit_val;
        if (commit_su) begin
          shutup <= shutup | slot_mask;
        end else begin
          cfg_done <= cfg_done | slot_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_minimig_autoconfig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_minimig_autoconfig_ctrl
// Self-checking bench for the AutoConfig chain controller. Drives CPU
// accesses against a modelled 512x4 ROM with registered address and data,
// and compares ack latency, read data and base reports to hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_minimig_autoconfig_ctrl;

  localparam int NB = 6;
  localparam int IW = 3;

  logic          clk;
  logic          reset_n;
  logic [NB-1:0] board_en;
  logic          cpu_req;
  logic          cpu_we;
  logic [5:0]    cpu_addr;
  logic [15:0]   cpu_din;
  logic [15:0]   cpu_dout;
  logic          cpu_ack;
  logic [IW+5:0] rom_a;
  logic [3:0]    rom_q;
  logic          base_we;
  logic [IW-1:0] base_idx;
  logic [15:0]   base_val;
  logic [NB-1:0] cfg_done;
  logic [NB-1:0] shutup;
  logic          chain_done;

  int checks = 0;
  int errors = 0;
  int bwe_count = 0;

  logic [3:0] rom_mem  [0:511];
  logic [3:0] type_tbl [0:7];
  logic [8:0] rom_a_r;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] din;
    logic        chk_dout;
    logic [15:0] dout;
    int          lat;
    logic        bwe;
    logic [2:0]  idx;
    logic [15:0] val;
  } vec_t;

  vec_t vecs [22];

  minimig_autoconfig_ctrl #(.NBOARDS(NB), .IDXW(IW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .board_en   (board_en),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_ack    (cpu_ack),
    .rom_a      (rom_a),
    .rom_q      (rom_q),
    .base_we    (base_we),
    .base_idx   (base_idx),
    .base_val   (base_val),
    .cfg_done   (cfg_done),
    .shutup     (shutup),
    .chain_done (chain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: registered address, then registered data.
  always @(posedge clk) begin
    rom_a_r <= rom_a;
    rom_q   <= rom_mem[rom_a_r];
  end

  // Count every base report pulse outside reset.
  always @(negedge clk) begin
    if (reset_n && base_we) bwe_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic we, input logic [5:0] a, input logic [15:0] d,
                              input logic cd, input logic [15:0] dout, input int lat,
                              input logic bwe, input logic [2:0] idx, input logic [15:0] val);
    vec_t v;
    v.we = we; v.addr = a; v.din = d; v.chk_dout = cd; v.dout = dout;
    v.lat = lat; v.bwe = bwe; v.idx = idx; v.val = val;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One CPU access: idle a cycle, raise the request, wait (bounded) for ack.
  task automatic applyStimulus(input logic we, input logic [5:0] a, input logic [15:0] d,
                               output int lat, output logic got_ack, output logic [15:0] dout,
                               output logic bwe, output logic [2:0] idx, output logic [15:0] val);
    @(posedge clk); #1;
    cpu_we = we; cpu_addr = a; cpu_din = d; cpu_req = 1'b1;
    lat = 0; got_ack = 1'b0; dout = 16'h0; bwe = 1'b0; idx = 3'd0; val = 16'h0;
    while (!got_ack && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ack) begin
        got_ack = 1'b1;
        dout = cpu_dout; bwe = base_we; idx = base_idx; val = base_val;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat; logic ga; logic [15:0] dout; logic bwe; logic [2:0] idx; logic [15:0] val;
    applyStimulus(v.we, v.addr, v.din, lat, ga, dout, bwe, idx, val);
    checkOutput({tag, " ack"}, 32'(ga), 32'd1);
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.lat));
    if (v.chk_dout) checkOutput({tag, " dout"}, 32'(dout), 32'(v.dout));
    checkOutput({tag, " base_we"}, 32'(bwe), 32'(v.bwe));
    if (v.bwe) begin
      checkOutput({tag, " base_idx"}, 32'(idx), 32'(v.idx));
      checkOutput({tag, " base_val"}, 32'(val), 32'(v.val));
    end
  endtask

  // Assert reset for about two cycles, then release just after a clock edge.
  task automatic run_reset(input logic [NB-1:0] en);
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 6'h00; cpu_din = 16'h0000;
    board_en = en;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int b0;
    type_tbl = '{4'hE, 4'hA, 4'hE, 4'hA, 4'h4, 4'hE, 4'hF, 4'hF};
    for (int a = 0; a < 512; a++) begin
      if (a[5:0] == 6'h00) rom_mem[a] = type_tbl[a >> 6];
      else                 rom_mem[a] = 4'(a[3:0]) ^ 4'(a >> 6);
    end

    // Full chain walk with every slot enabled; types E,A,E,A,4,E.
    vecs[0]  = mk(0, 6'h03, 16'h0000, 1, 16'h3fff, 4, 0, 3'd0, 16'h0000);
    vecs[1]  = mk(1, 6'h25, 16'h0000, 0, 16'h0000, 1, 0, 3'd0, 16'h0000);
    vecs[2]  = mk(1, 6'h10, 16'hffff, 0, 16'h0000, 1, 0, 3'd0, 16'h0000);
    vecs[3]  = mk(1, 6'h22, 16'h1234, 0, 16'h0000, 1, 0, 3'd0, 16'h0000);
    vecs[4]  = mk(1, 6'h24, 16'h2000, 0, 16'h0000, 1, 1, 3'd0, 16'h0020);
    vecs[5]  = mk(0, 6'h00, 16'h0000, 1, 16'hafff, 7, 0, 3'd0, 16'h0000);
    vecs[6]  = mk(0, 6'h05, 16'h0000, 1, 16'h4fff, 4, 0, 3'd0, 16'h0000);
    vecs[7]  = mk(1, 6'h24, 16'h9000, 0, 16'h0000, 1, 0, 3'd0, 16'h0000);
    vecs[8]  = mk(1, 6'h22, 16'h4000, 0, 16'h0000, 1, 1, 3'd1, 16'h4000);
    vecs[9]  = mk(0, 6'h00, 16'h0000, 1, 16'hefff, 7, 0, 3'd0, 16'h0000);
    vecs[10] = mk(1, 6'h25, 16'hb000, 0, 16'h0000, 1, 0, 3'd0, 16'h0000);
    vecs[11] = mk(1, 6'h24, 16'h7000, 0, 16'h0000, 1, 1, 3'd2, 16'h007b);
    vecs[12] = mk(0, 6'h02, 16'h0000, 1, 16'h1fff, 7, 0, 3'd0, 16'h0000);
    vecs[13] = mk(1, 6'h25, 16'hc000, 0, 16'h0000, 1, 0, 3'd0, 16'h0000);
    vecs[14] = mk(1, 6'h26, 16'hffff, 0, 16'h0000, 1, 1, 3'd3, 16'h0000);
    vecs[15] = mk(0, 6'h0c, 16'h0000, 1, 16'h8fff, 7, 0, 3'd0, 16'h0000);
    vecs[16] = mk(1, 6'h24, 16'h5000, 0, 16'h0000, 1, 1, 3'd4, 16'h0050);
    vecs[17] = mk(0, 6'h01, 16'h0000, 1, 16'h4fff, 7, 0, 3'd0, 16'h0000);
    vecs[18] = mk(1, 6'h25, 16'h3000, 0, 16'h0000, 1, 0, 3'd0, 16'h0000);
    vecs[19] = mk(1, 6'h24, 16'h6000, 0, 16'h0000, 1, 1, 3'd5, 16'h0063);
    vecs[20] = mk(0, 6'h00, 16'h0000, 1, 16'hffff, 1, 0, 3'd0, 16'h0000);
    vecs[21] = mk(1, 6'h24, 16'h1000, 0, 16'h0000, 1, 0, 3'd0, 16'h0000);

    // Reset values, checked while reset is still asserted.
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 6'h00; cpu_din = 16'h0000;
    board_en = 6'b111111;
    @(posedge clk); #1;
    checkOutput("reset cpu_ack", 32'(cpu_ack), 32'd0);
    checkOutput("reset cpu_dout", 32'(cpu_dout), 32'hffff);
    checkOutput("reset rom_a", 32'(rom_a), 32'd0);
    checkOutput("reset base_we", 32'(base_we), 32'd0);
    checkOutput("reset base_idx", 32'(base_idx), 32'd0);
    checkOutput("reset base_val", 32'(base_val), 32'd0);
    checkOutput("reset cfg_done", 32'(cfg_done), 32'd0);
    checkOutput("reset shutup", 32'(shutup), 32'd0);
    checkOutput("reset chain_done", 32'(chain_done), 32'd0);

    run_reset(6'b111111);
    b0 = bwe_count;
    repeat (3) @(posedge clk);
    run_vec(mk(0, 6'h00, 16'h0000, 1, 16'hefff, 4, 0, 3'd0, 16'h0000), "first read");
    for (int i = 0; i < 22; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    checkOutput("walk cfg_done", 32'(cfg_done), 32'h37);
    checkOutput("walk shutup", 32'(shutup), 32'h08);
    checkOutput("walk chain_done", 32'(chain_done), 32'd1);
    checkOutput("walk base_we count", 32'(bwe_count - b0), 32'd6);

    // Sparse chain: slots 1..4 skipped, last slot shut up.
    run_reset(6'b100001);
    b0 = bwe_count;
    repeat (3) @(posedge clk);
    run_vec(mk(0, 6'h00, 16'h0000, 1, 16'hefff, 4, 0, 3'd0, 16'h0000), "sparse s0 read");
    run_vec(mk(1, 6'h25, 16'h0000, 0, 16'h0000, 1, 0, 3'd0, 16'h0000), "sparse lo");
    run_vec(mk(1, 6'h24, 16'h1000, 0, 16'h0000, 1, 1, 3'd0, 16'h0010), "sparse s0 base");
    run_vec(mk(0, 6'h00, 16'h0000, 1, 16'hefff, 11, 0, 3'd0, 16'h0000), "sparse s5 read");
    board_en = 6'b000000;
    run_vec(mk(0, 6'h03, 16'h0000, 1, 16'h6fff, 4, 0, 3'd0, 16'h0000), "sparse en change");
    run_vec(mk(1, 6'h26, 16'h0000, 0, 16'h0000, 1, 1, 3'd5, 16'h0000), "sparse shutup");
    @(posedge clk); #1;
    checkOutput("sparse chain_done", 32'(chain_done), 32'd1);
    run_vec(mk(0, 6'h00, 16'h0000, 1, 16'hffff, 1, 0, 3'd0, 16'h0000), "sparse done read");
    checkOutput("sparse shutup flags", 32'(shutup), 32'h20);
    checkOutput("sparse cfg_done", 32'(cfg_done), 32'h01);
    checkOutput("sparse base_we count", 32'(bwe_count - b0), 32'd2);

    // Empty chain.
    run_reset(6'b000000);
    b0 = bwe_count;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("empty chain_done", 32'(chain_done), 32'd1);
    run_vec(mk(0, 6'h00, 16'h0000, 1, 16'hffff, 1, 0, 3'd0, 16'h0000), "empty read");
    checkOutput("empty base_we count", 32'(bwe_count - b0), 32'd0);

    // Reset in the middle of a read in slot 2.
    run_reset(6'b111111);
    repeat (3) @(posedge clk);
    run_vec(mk(1, 6'h24, 16'h2000, 0, 16'h0000, 1, 1, 3'd0, 16'h0020), "midrst s0");
    run_vec(mk(0, 6'h00, 16'h0000, 1, 16'hafff, 7, 0, 3'd0, 16'h0000), "midrst s1 read");
    run_vec(mk(1, 6'h22, 16'h4000, 0, 16'h0000, 1, 1, 3'd1, 16'h4000), "midrst s1");
    checkOutput("midrst cfg before", 32'(cfg_done), 32'h03);
    repeat (4) @(posedge clk);
    #1;
    cpu_we = 1'b0; cpu_addr = 6'h04; cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("midrst no ack %0d", k), 32'(cpu_ack), 32'd0);
    end
    checkOutput("midrst cfg cleared", 32'(cfg_done), 32'd0);
    checkOutput("midrst rom_a", 32'(rom_a), 32'd0);
    checkOutput("midrst dout", 32'(cpu_dout), 32'hffff);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    run_vec(mk(0, 6'h00, 16'h0000, 1, 16'hefff, 4, 0, 3'd0, 16'h0000), "midrst restart");
    checkOutput("midrst cfg after", 32'(cfg_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
